// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; HAMDIS optionally widened to 32 bits over four passes.
// Latency: response 2 cycles after accept (5 for extended HAMDIS); next accept 1 cycle after the response.
// Backpressure: reqN_ready only in IDLE for the granted requester; responses cannot be stalled.
module alu_share_ctrl #(
    parameter bit EXT_HAMDIS = 1'b1,
    parameter bit PRIO_INIT  = 1'b0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_aluc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_aluc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_s,
    input  logic        alu_z,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_s,
    output logic        rsp_z
);
    localparam logic [3:0] OP_HAMDIS = 4'b1011;

    typedef enum logic [1:0] {IDLE, EXEC, HAM, RESP} state_t;

    state_t      state;
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic [3:0]  aluc_lat;
    logic        id_lat;
    logic [1:0]  k;
    logic [5:0]  acc;
    logic        last_grant;

    logic        grant0;
    logic        grant1;
    logic        sel_id;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_aluc;
    logic [4:0]  shamt;
    logic [5:0]  acc_next;

    // Round-robin: on contention the requester that did not win last time goes first.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        sel_id     = grant1;
        sel_a      = sel_id ? req1_a    : req0_a;
        sel_b      = sel_id ? req1_b    : req0_b;
        sel_aluc   = sel_id ? req1_aluc : req0_aluc;
        shamt      = {k, 3'b000};
        alu_a      = (state == HAM) ? (a_lat >> shamt) : a_lat;
        alu_b      = (state == HAM) ? (b_lat >> shamt) : b_lat;
        alu_aluc   = aluc_lat;
        acc_next   = acc + alu_s[5:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            a_lat      <= '0;
            b_lat      <= '0;
            aluc_lat   <= '0;
            id_lat     <= 1'b0;
            k          <= '0;
            acc        <= '0;
            last_grant <= ~PRIO_INIT;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_s      <= '0;
            rsp_z      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (grant0 || grant1) begin
                        a_lat      <= sel_a;
                        b_lat      <= sel_b;
                        aluc_lat   <= sel_aluc;
                        id_lat     <= sel_id;
                        last_grant <= sel_id;
                        if (EXT_HAMDIS && (sel_aluc == OP_HAMDIS)) begin
                            acc   <= '0;
                            k     <= '0;
                            state <= HAM;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_s     <= alu_s;
                    rsp_z     <= alu_z;
                    rsp_id    <= id_lat;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                HAM: begin
                    // Each pass contributes the popcount of one byte lane (at most 8).
                    acc <= acc_next;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
                        rsp_s     <= {26'b0, acc_next};
                        rsp_z     <= (acc_next == 6'd0);
                        rsp_id    <= id_lat;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl with a cycle-count reference model and a behavioural ALU.
module tb_alu_share_ctrl;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_aluc = '0, req1_aluc = '0;
    logic        req0_ready, req1_ready;
    logic [31:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_aluc;
    logic        alu_z;
    logic        rsp_valid, rsp_id, rsp_z;
    logic [31:0] rsp_s;

    // second instance with single-pass HAMDIS
    logic        x_req0_valid = 1'b0;
    logic [31:0] x_req0_a = '0, x_req0_b = '0;
    logic [3:0]  x_req0_aluc = '0;
    logic        x_req1_valid = 1'b0;
    logic [31:0] x_req1_a = '0, x_req1_b = '0;
    logic [3:0]  x_req1_aluc = '0;
    logic        x_req0_ready, x_req1_ready;
    logic [31:0] x_alu_a, x_alu_b, x_alu_s;
    logic [3:0]  x_alu_aluc;
    logic        x_alu_z;
    logic        x_rsp_valid, x_rsp_id, x_rsp_z;
    logic [31:0] x_rsp_s;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] x;
        x = a ^ b;
        casez (c)
            4'b?000: return a + b;
            4'b?100: return a - b;
            4'b?001: return a & b;
            4'b?101: return a | b;
            4'b?010: return a ^ b;
            4'b?110: return {b[15:0], 16'h0000};
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return $signed(b) >>> a[4:0];
            default: return 32'($countones(x[7:0]));
        endcase
    endfunction

    assign alu_s   = alu_fn(alu_a, alu_b, alu_aluc);
    assign alu_z   = (alu_s == 32'd0);
    assign x_alu_s = alu_fn(x_alu_a, x_alu_b, x_alu_aluc);
    assign x_alu_z = (x_alu_s == 32'd0);

    alu_share_ctrl #(.EXT_HAMDIS(1'b1), .PRIO_INIT(1'b0)) dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_z(rsp_z)
    );

    alu_share_ctrl #(.EXT_HAMDIS(1'b0), .PRIO_INIT(1'b0)) dut_x (
        .clock(clock), .resetn(resetn),
        .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_aluc(x_req0_aluc),
        .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_a(x_req1_a), .req1_b(x_req1_b), .req1_aluc(x_req1_aluc),
        .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_aluc(x_alu_aluc), .alu_s(x_alu_s), .alu_z(x_alu_z),
        .rsp_valid(x_rsp_valid), .rsp_id(x_rsp_id), .rsp_s(x_rsp_s), .rsp_z(x_rsp_z)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: the block is busy for a fixed number of cycles after each accept.
    typedef struct {bit id; logic [31:0] s; bit z; int lat;} rsp_t;
    rsp_t log_q[$];

    int          cyc = 0;
    int          busy = 0;
    int          due = -1;
    int          pend_cyc = 0;
    bit          rr_last = 1'b1;
    bit          pend_id, hold_id;
    logic [31:0] pend_s, hold_s;
    bit          pend_z, hold_z;
    bit          acc0 = 1'b0, acc1 = 1'b0;

    always @(negedge clock) begin
        bit          e0, e1, ext;
        logic [31:0] ma, mb;
        logic [3:0]  mc;
        cyc++;
        if (!resetn) begin
            check("reset", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_s, alu_a, alu_b, alu_aluc}, '0);
            busy = 0; due = -1; rr_last = 1'b1;
            hold_id = 1'b0; hold_s = '0; hold_z = 1'b0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            if (busy > 0) busy--;
            if (due >= 0) due--;
            if (due == 0) begin
                hold_id = pend_id; hold_s = pend_s; hold_z = pend_z;
            end
            e0 = (busy == 0) && req0_valid && (!req1_valid || rr_last);
            e1 = (busy == 0) && req1_valid && (!req0_valid || !rr_last);
            check("ready", {req0_ready, req1_ready}, {e0, e1});
            check("rsp", {rsp_valid, rsp_id, rsp_z, rsp_s}, {(due == 0), hold_id, hold_z, hold_s});
            if (rsp_valid) log_q.push_back('{rsp_id, rsp_s, rsp_z, cyc - pend_cyc});
            if (e0 || e1) begin
                ma = e1 ? req1_a : req0_a;
                mb = e1 ? req1_b : req0_b;
                mc = e1 ? req1_aluc : req0_aluc;
                ext = (mc == 4'b1011);
                pend_id  = e1;
                pend_s   = ext ? 32'($countones(ma ^ mb)) : alu_fn(ma, mb, mc);
                pend_z   = (pend_s == 32'd0);
                due      = ext ? 5 : 2;
                busy     = due + 1;
                pend_cyc = cyc;
                rr_last  = e1;
            end
            acc0 = e0;
            acc1 = e1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = c;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((req0_valid || req1_valid || busy != 0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic check_log(input string name, input int idx, input bit id, input logic [31:0] s,
                             input bit z, input int lat);
        if (log_q.size() <= idx) check({name, "_missing"}, log_q.size(), idx + 1);
        else check(name, {log_q[idx].id, log_q[idx].z, log_q[idx].s, 32'(log_q[idx].lat)},
                   {id, z, s, 32'(lat)});
    endtask

    task automatic rand_req(input bit id);
        logic [31:0] a, b, r;
        logic [3:0]  c;
        a = $urandom; b = $urandom; r = $urandom;
        c = r[3:0];
        if (r[5:4] == 2'd0) c = 4'b1011;
        if (r[6]) a = a & 32'h1F;
        set_req(id, a, b, c);
    endtask

    initial begin
        bit got_acc, got_rsp;
        int t0;
        #2 resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // contention from reset: req0 first, req1 next
        log_q.delete();
        set_req(0, 32'd9, 32'd9, 4'b0100);
        set_req(1, 32'd9, 32'd9, 4'b0100);
        wait_idle("contend");
        check_log("contend_r0", 0, 1'b0, 32'd0, 1'b1, 2);
        check_log("contend_r1", 1, 1'b1, 32'd0, 1'b1, 2);

        log_q.delete();
        set_req(0, 32'd1, 32'd2, 4'b0000);
        set_req(1, 32'd3, 32'd4, 4'b0000);
        wait_idle("contend2");
        check_log("contend2_first", 0, 1'b0, 32'd3, 1'b0, 2);

        log_q.delete();
        set_req(0, 32'd5, 32'd7, 4'b0000);
        wait_idle("add");
        check_log("add", 0, 1'b0, 32'd12, 1'b0, 2);

        log_q.delete();
        set_req(1, 32'hFFFF_FFFF, 32'h0, 4'b1011);
        wait_idle("ham32");
        set_req(1, 32'h1234_5678, 32'h1234_5678, 4'b1011);
        wait_idle("ham0");
        check_log("ham32", 0, 1'b1, 32'd32, 1'b0, 5);
        check_log("ham0", 1, 1'b1, 32'd0, 1'b1, 5);

        log_q.delete();
        set_req(0, 32'd4, 32'h8000_0000, 4'b1111);
        wait_idle("sra");
        set_req(1, 32'd0, 32'h0000_ABCD, 4'b0110);
        wait_idle("lui");
        check_log("sra", 0, 1'b0, 32'hF800_0000, 1'b0, 2);
        check_log("lui", 1, 1'b1, 32'hABCD_0000, 1'b0, 2);

        // reset during pass k=2 of an extended HAMDIS
        log_q.delete();
        set_req(0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b1011);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1 check("abort_immediate", {rsp_valid, rsp_id, rsp_z, rsp_s, alu_a, alu_b, alu_aluc}, '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        repeat (8) tick();
        check("abort_no_rsp", log_q.size(), 0);
        set_req(0, 32'd10, 32'd20, 4'b0000);
        set_req(1, 32'd1, 32'd1, 4'b0000);
        wait_idle("post_abort");
        check_log("post_abort_first", 0, 1'b0, 32'd30, 1'b0, 2);
        check_log("post_abort_second", 1, 1'b1, 32'd2, 1'b0, 2);

        // single-pass HAMDIS instance
        x_req0_valid = 1'b1; x_req0_a = 32'hFF00_0001; x_req0_b = 32'h0; x_req0_aluc = 4'b1011;
        got_acc = 1'b0; got_rsp = 1'b0; t0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (x_rsp_valid && !got_rsp) begin
                got_rsp = 1'b1;
                check("x_ham8", {x_rsp_z, x_rsp_s, 32'(i - t0)}, {1'b0, 32'd1, 32'd2});
            end
            if (x_req0_ready && !got_acc) begin
                got_acc = 1'b1;
                t0 = i;
            end
            @(posedge clock);
            #1;
            if (got_acc) x_req0_valid = 1'b0;
        end
        check("x_ham8_seen", {got_acc, got_rsp}, 2'b11);

        // randomized traffic from both requesters
        for (int n = 0; n < 400; n++) begin
            if (!req0_valid && $urandom_range(2) == 0) rand_req(1'b0);
            if (!req1_valid && $urandom_range(2) == 0) rand_req(1'b1);
            tick();
        end
        wait_idle("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
